controller: RTL and testbench

CONTROLLER -- requirements
Module: controller

---
 rtl/typedefs.sv | 12 +
 rtl/ctrl_decode.sv | 46 ++++
 rtl/controller.sv | 76 +++++++
 tb/tb_controller.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/typedefs.sv
// typedefs: shared opcode and FSM-state types for the controller
// Ports: none (package). Provides opcode_t, state_t and is_aluop().
package typedefs;
  typedef enum logic [2:0] {HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP} opcode_t;
  typedef enum logic [2:0] {
    INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
  } state_t;
  // Opcodes whose operand is read from memory into the accumulator
  function automatic logic is_aluop(opcode_t op);
    return op inside {ADD, AND, XOR, LDA};
  endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational datapath-strobe decode from phase, opcode and zero
// Ports: phase/opcode/zero/halted in; mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr out.
module ctrl_decode
  import typedefs::*;
(
  input  state_t  phase,
  input  opcode_t opcode,
  input  logic    zero,
  input  logic    halted,
  output logic    mem_rd,
  output logic    load_ir,
  output logic    halt,
  output logic    inc_pc,
  output logic    load_ac,
  output logic    load_pc,
  output logic    mem_wr
);
  logic alu;
  logic late;
  assign alu  = is_aluop(opcode);
  assign late = phase == ALU_OP || phase == STORE;
  // A latched halt masks every strobe except halt itself
  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      mem_rd  = phase inside {INST_FETCH, INST_LOAD, IDLE} ||
                (phase inside {OP_FETCH, ALU_OP, STORE} && alu);
      load_ir = phase inside {INST_LOAD, IDLE};
      halt    = phase == OP_ADDR && opcode == HLT;
      inc_pc  = (phase == OP_ADDR && opcode != HLT) ||
                (phase == ALU_OP && opcode == SKZ && zero) ||
                (phase == STORE && opcode == JMP);
      load_ac = late && alu;
      load_pc = late && opcode == JMP;
      mem_wr  = phase == STORE && opcode == STO;
    end
  end
endmodule

// File: rtl/controller.sv
// controller: 8-phase instruction-sequencing FSM with halt latch and retired-instruction counter
// Ports: clk, rst (sync, active-high), opcode, zero, [step when CONTROLLER_STEP_EN];
//        strobes mem_rd/load_ir/halt/inc_pc/load_ac/load_pc/mem_wr, phase, instr_count.
// Macro CONTROLLER_STEP_EN adds single-step gating at INST_ADDR.
module controller
  import typedefs::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef CONTROLLER_STEP_EN
  input  logic                 step,
`endif
  input  opcode_t              opcode,
  input  logic                 zero,
  output logic                 mem_rd,
  output logic                 load_ir,
  output logic                 halt,
  output logic                 inc_pc,
  output logic                 load_ac,
  output logic                 load_pc,
  output logic                 mem_wr,
  output state_t               phase,
  output logic [CNT_WIDTH-1:0] instr_count
);
  state_t               state_q, state_d;
  logic                 halted_q, halted_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 go;
`ifdef CONTROLLER_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif
  // HLT freezes in OP_ADDR before STORE, so a halted instruction never reaches the counter
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    if (!halted_q) begin
      if (state_q == OP_ADDR && opcode == HLT) begin
        halted_d = 1'b1;
      end else if (state_q != INST_ADDR || go) begin
        state_d = state_t'(state_q + 3'd1);
        cnt_d   = state_q == STORE ? cnt_q + CNT_WIDTH'(1) : cnt_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INST_ADDR;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end
  assign phase       = state_q;
  assign instr_count = cnt_q;
  ctrl_decode u_decode (
    .phase  (state_q),
    .opcode (opcode),
    .zero   (zero),
    .halted (halted_q),
    .mem_rd (mem_rd),
    .load_ir(load_ir),
    .halt   (halt),
    .inc_pc (inc_pc),
    .load_ac(load_ac),
    .load_pc(load_pc),
    .mem_wr (mem_wr)
  );
endmodule

// File: tb/tb_controller.sv
// tb_controller: randomized self-checking bench for controller against a phase-table model
module tb_controller;
  import typedefs::*;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, step = 1'b1;
  opcode_t opcode = ADD;
  logic mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
  state_t phase;
  logic [W-1:0] instr_count;
  logic [6:0] got;
  int checks = 0, errors = 0;
  int m_phase = 0, m_cnt = 0;
  bit m_halt = 0;
  always #5 clk = ~clk;
  assign got = {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};
  controller #(.CNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
`ifdef CONTROLLER_STEP_EN
    .step(step),
`endif
    .opcode(opcode), .zero(zero),
    .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt), .inc_pc(inc_pc),
    .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr),
    .phase(phase), .instr_count(instr_count)
  );
  // Expected strobes: per-opcode bitmasks over the eight phases, bit i = phase i
  function automatic logic [6:0] exp_strobes();
    bit alu = opcode inside {ADD, AND, XOR, LDA};
    logic [7:0] rd, ir, hl, inc, ac, pc, wr;
    if (m_halt) return 7'b0010000;
    rd  = 8'h0E | (alu ? 8'hE0 : 8'h00);
    ir  = 8'h0C;
    hl  = opcode == HLT ? 8'h10 : 8'h00;
    inc = (opcode != HLT ? 8'h10 : 8'h00) | (opcode == SKZ && zero ? 8'h40 : 8'h00) |
          (opcode == JMP ? 8'h80 : 8'h00);
    ac  = alu ? 8'hC0 : 8'h00;
    pc  = opcode == JMP ? 8'hC0 : 8'h00;
    wr  = opcode == STO ? 8'h80 : 8'h00;
    return {rd[m_phase], ir[m_phase], hl[m_phase], inc[m_phase], ac[m_phase], pc[m_phase], wr[m_phase]};
  endfunction
  // Advance one clock and update the model from the inputs seen at that edge
  task automatic tick();
    bit gated = 0;
`ifdef CONTROLLER_STEP_EN
    gated = !step;
`endif
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_halt = 0;
    end else if (!m_halt) begin
      if (m_phase == 4 && opcode == HLT) m_halt = 1;
      else if (!(m_phase == 0 && gated)) begin
        if (m_phase == 7) m_cnt = (m_cnt + 1) % (1 << W);
        m_phase = (m_phase + 1) % 8;
      end
    end
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
    checks += 3;
    if (phase !== INST_ADDR) begin errors++; $display("FAIL reset_phase got=%0d want=0", phase); end
    if (got !== 7'b0) begin errors++; $display("FAIL reset_strobes got=%b want=0000000", got); end
    if (instr_count !== '0) begin errors++; $display("FAIL reset_count got=%0d want=0", instr_count); end
    tick(); #1;
    checks++;
    if (phase !== INST_FETCH) begin errors++; $display("FAIL reset_next got=%0d want=1", phase); end
  endtask
  task automatic test_add();
    do_reset(); opcode = ADD; zero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1; checks += 2;
      if (phase !== state_t'(m_phase)) begin errors++; $display("FAIL add_phase got=%0d want=%0d", phase, m_phase); end
      if (got !== exp_strobes()) begin errors++; $display("FAIL add_strobes ph=%0d got=%b want=%b", m_phase, got, exp_strobes()); end
      tick();
    end
    #1; checks++;
    if (instr_count !== W'(1)) begin errors++; $display("FAIL add_count got=%0d want=1", instr_count); end
  endtask
  task automatic test_ops();
    opcode_t ops[4] = '{SKZ, SKZ, JMP, STO};
    logic zs[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      opcode = ops[k]; zero = zs[k];
      for (int i = 0; i < 8; i++) begin
        #1; checks += 3;
        if (phase !== state_t'(m_phase)) begin errors++; $display("FAIL ops_phase op=%0d got=%0d want=%0d", ops[k], phase, m_phase); end
        if (got !== exp_strobes()) begin errors++; $display("FAIL ops_strobes op=%0d z=%b ph=%0d got=%b want=%b", ops[k], zs[k], m_phase, got, exp_strobes()); end
        if (mem_rd && mem_wr) begin errors++; $display("FAIL ops_rdwr ph=%0d got=11 want=not both", m_phase); end
        tick();
      end
    end
    #1; checks++;
    if (instr_count !== W'(m_cnt)) begin errors++; $display("FAIL ops_count got=%0d want=%0d", instr_count, m_cnt); end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 320; i++) begin
      opcode = opcode_t'($urandom_range(1, 7)); zero = 1'($urandom_range(0, 1));
      #1; checks += 3;
      if (phase !== state_t'(m_phase)) begin errors++; $display("FAIL rnd_phase got=%0d want=%0d", phase, m_phase); end
      if (got !== exp_strobes()) begin errors++; $display("FAIL rnd_strobes op=%0d ph=%0d got=%b want=%b", opcode, m_phase, got, exp_strobes()); end
      if (instr_count !== W'(m_cnt)) begin errors++; $display("FAIL rnd_count got=%0d want=%0d", instr_count, m_cnt); end
      tick();
    end
  endtask
  task automatic test_wrap();
    do_reset(); opcode = ADD; zero = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      repeat (8) tick();
      #1; checks++;
      if (instr_count !== W'(m_cnt)) begin errors++; $display("FAIL wrap_count n=%0d got=%0d want=%0d", n, instr_count, m_cnt); end
    end
    checks++;
    if (instr_count !== '0) begin errors++; $display("FAIL wrap_zero got=%0d want=0", instr_count); end
  endtask
  task automatic test_halt();
    int saved;
    do_reset(); opcode = ADD; zero = 1'b0;
    repeat (8) tick();
    saved = m_cnt;
    opcode = HLT;
    repeat (4) tick();
    #1; checks += 2;
    if (phase !== OP_ADDR) begin errors++; $display("FAIL halt_enter got=%0d want=4", phase); end
    if (got !== 7'b0010000) begin errors++; $display("FAIL halt_first got=%b want=0010000", got); end
    tick();
    for (int i = 0; i < 20; i++) begin
      opcode = opcode_t'($urandom_range(0, 7)); zero = 1'($urandom_range(0, 1));
      #1; checks += 3;
      if (phase !== OP_ADDR) begin errors++; $display("FAIL halt_phase got=%0d want=4", phase); end
      if (got !== 7'b0010000) begin errors++; $display("FAIL halt_strobes got=%b want=0010000", got); end
      if (instr_count !== W'(saved)) begin errors++; $display("FAIL halt_count got=%0d want=%0d", instr_count, saved); end
      tick();
    end
    opcode = ADD; rst = 1'b1; tick(); rst = 1'b0; #1;
    checks += 2;
    if (phase !== INST_ADDR) begin errors++; $display("FAIL halt_rst_phase got=%0d want=0", phase); end
    if (got !== 7'b0) begin errors++; $display("FAIL halt_rst_strobes got=%b want=0000000", got); end
    tick(); #1; checks++;
    if (phase !== INST_FETCH) begin errors++; $display("FAIL halt_restart got=%0d want=1", phase); end
  endtask
  task automatic test_reset_mid();
    do_reset(); opcode = ADD; zero = 1'b0;
    repeat (6) tick();
    #1; checks++;
    if (load_ac !== 1'b1) begin errors++; $display("FAIL mid_pre_load_ac got=%b want=1", load_ac); end
    rst = 1'b1; tick(); #1;
    checks += 3;
    if (phase !== INST_ADDR) begin errors++; $display("FAIL mid_phase got=%0d want=0", phase); end
    if (load_ac !== 1'b0) begin errors++; $display("FAIL mid_load_ac got=%b want=0", load_ac); end
    if (got !== 7'b0) begin errors++; $display("FAIL mid_strobes got=%b want=0000000", got); end
    rst = 1'b0;
  endtask
`ifdef CONTROLLER_STEP_EN
  task automatic test_step();
    step = 1'b0; do_reset(); opcode = ADD;
    for (int i = 0; i < 10; i++) begin
      tick(); checks++;
      if (phase !== INST_ADDR) begin errors++; $display("FAIL step_hold got=%0d want=0", phase); end
    end
    step = 1'b1; tick(); step = 1'b0;
    for (int i = 1; i < 13; i++) begin
      #1; checks++;
      if (phase !== state_t'(i < 8 ? i : 0)) begin errors++; $display("FAIL step_run i=%0d got=%0d want=%0d", i, phase, i < 8 ? i : 0); end
      tick();
    end
    #1; checks++;
    if (instr_count !== W'(1)) begin errors++; $display("FAIL step_count got=%0d want=1", instr_count); end
    step = 1'b1;
  endtask
`endif
  initial begin
    test_reset();
    test_add();
    test_ops();
    test_random();
    test_wrap();
    test_halt();
    test_reset_mid();
`ifdef CONTROLLER_STEP_EN
    test_step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
